// File: rtl/ternary_pkg.sv
// Shared types and constants for the ternary matrix-vector session sequencer.
package ternary_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSettle,
    StVecWait,
    StIssue,
    StMacWait,
    StOut
  } seq_state_e;

  // Weight loader consumes each row as two bit-planes, MSB first.
  localparam logic PHASE_MSB = 1'b0;
  localparam logic PHASE_LSB = 1'b1;

  localparam int unsigned CFG_W       = 7;
  localparam int unsigned CFG_OUT_LSB = 0;
  localparam int unsigned CFG_OUT_MSB = 2;
  localparam int unsigned CFG_IN_LSB  = 3;
  localparam int unsigned CFG_IN_MSB  = 6;

endpackage

// File: rtl/ternary_seq_lat_ctr.sv
// MAC latency down-counter: loaded on issue, flags done when the result is due.
module ternary_seq_lat_ctr #(
  parameter int unsigned Lat = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic done_o
);

  localparam int unsigned CntW = (Lat > 1) ? $clog2(Lat) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CntW'(Lat - 1);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/ternary_seq_ctrl.sv
// Session sequencer: weight load, vector accept, per-row MAC issue and result stream.
// Define SEQ_PERF_EN to add the o_vec_cnt / o_stall_cnt performance counters.
module ternary_seq_ctrl
  import ternary_pkg::*;
#(
  parameter  int unsigned MAX_IN_LEN  = 16,
  parameter  int unsigned MAX_OUT_LEN = 8,
  parameter  int unsigned ACC_W       = 8,
  parameter  int unsigned MAC_LAT     = 1,
  localparam int unsigned OUT_BITS    = $clog2(MAX_OUT_LEN)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic [CFG_W-1:0]    i_cfg,
  input  logic                i_stop,
  output logic [CFG_W-1:0]    o_cfg,
  output logic                o_load_ena,
  input  logic                i_load_done,
  input  logic                i_vec_valid,
  output logic                o_vec_ready,
  output logic [OUT_BITS-1:0] o_row_sel,
  output logic                o_mac_en,
  input  logic [ACC_W-1:0]    i_mac_res,
  output logic                o_res_valid,
  input  logic                i_res_ready,
  output logic [ACC_W-1:0]    o_res_data,
  output logic                o_res_last,
  output logic                o_busy,
  output logic                o_err
`ifdef SEQ_PERF_EN
  ,
  output logic [15:0]         o_vec_cnt,
  output logic [15:0]         o_stall_cnt
`endif
);

  localparam int unsigned OutFw = CFG_OUT_MSB - CFG_OUT_LSB + 1;
  localparam int unsigned InFw  = CFG_IN_MSB - CFG_IN_LSB + 1;
  localparam logic [OutFw-1:0] OutM1Max = OutFw'(MAX_OUT_LEN - 1);
  localparam logic [InFw-1:0]  InM1Max  = InFw'(MAX_IN_LEN - 1);

  seq_state_e          state_q, state_d;
  logic [CFG_W-1:0]    cfg_q, cfg_d;
  logic [OUT_BITS-1:0] row_q, row_d;
  logic                phase_q, phase_d;
  logic                err_q, err_d;
  logic [ACC_W-1:0]    res_q, res_d;

  logic [OutFw-1:0] out_m1_raw, out_m1;
  logic [InFw-1:0]  in_m1_raw, in_m1;
  logic             last_row;
  logic             start_acc;
  logic             vec_acc;
  logic             lat_done;

  // Lengths beyond the datapath width are clamped so row_sel stays in range.
  assign out_m1_raw = i_cfg[CFG_OUT_MSB:CFG_OUT_LSB];
  assign in_m1_raw  = i_cfg[CFG_IN_MSB:CFG_IN_LSB];
  assign out_m1     = (out_m1_raw > OutM1Max) ? OutM1Max : out_m1_raw;
  assign in_m1      = (in_m1_raw > InM1Max) ? InM1Max : in_m1_raw;

  assign last_row  = (row_q == OUT_BITS'(cfg_q[CFG_OUT_MSB:CFG_OUT_LSB]));
  assign start_acc = (state_q == StIdle) && i_start;
  assign vec_acc   = (state_q == StVecWait) && i_vec_valid;

  ternary_seq_lat_ctr #(
    .Lat (MAC_LAT)
  ) u_lat_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (state_q == StIssue),
    .en_i   (state_q == StMacWait),
    .done_o (lat_done)
  );

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    row_d   = row_q;
    phase_d = phase_q;
    err_d   = err_q;
    res_d   = res_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d = StLoad;
          cfg_d   = {in_m1, out_m1};
          err_d   = 1'b0;
          row_d   = '0;
          phase_d = PHASE_MSB;
        end
      end
      StLoad: begin
        if (phase_q == PHASE_MSB) begin
          phase_d = PHASE_LSB;
        end else if (last_row) begin
          if (!i_load_done) err_d = 1'b1;
          state_d = StSettle;
        end else begin
          row_d   = row_q + 1'b1;
          phase_d = PHASE_MSB;
        end
      end
      StSettle: state_d = StVecWait;
      StVecWait: begin
        // A vector arriving with i_stop takes priority over ending the session.
        if (i_vec_valid) begin
          state_d = StIssue;
          row_d   = '0;
        end else if (i_stop) begin
          state_d = StIdle;
        end
      end
      StIssue: state_d = StMacWait;
      StMacWait: begin
        if (lat_done) begin
          res_d   = i_mac_res;
          state_d = StOut;
        end
      end
      StOut: begin
        if (i_res_ready) begin
          if (last_row) begin
            state_d = StVecWait;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = StIssue;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cfg_q   <= '0;
      row_q   <= '0;
      phase_q <= PHASE_MSB;
      err_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      row_q   <= row_d;
      phase_q <= phase_d;
      err_q   <= err_d;
      res_q   <= res_d;
    end
  end

  assign o_cfg       = cfg_q;
  assign o_load_ena  = (state_q == StLoad);
  assign o_vec_ready = (state_q == StVecWait);
  assign o_row_sel   = row_q;
  assign o_mac_en    = (state_q == StIssue);
  assign o_res_valid = (state_q == StOut);
  assign o_res_data  = res_q;
  assign o_res_last  = (state_q == StOut) && last_row;
  assign o_busy      = (state_q != StIdle);
  assign o_err       = err_q;

`ifdef SEQ_PERF_EN
  logic [15:0] vec_cnt_q, vec_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    vec_cnt_d   = vec_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (start_acc) begin
      vec_cnt_d   = '0;
      stall_cnt_d = '0;
    end else begin
      if (vec_acc && (vec_cnt_q != 16'hFFFF)) vec_cnt_d = vec_cnt_q + 16'd1;
      if ((state_q == StOut) && !i_res_ready && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_d = stall_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vec_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      vec_cnt_q   <= vec_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_vec_cnt   = vec_cnt_q;
  assign o_stall_cnt = stall_cnt_q;
`else
  logic unused_acc;
  assign unused_acc = start_acc ^ vec_acc;
`endif

endmodule
